// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: 2-flop synchroniser, receive FSM, FIFO, DATA/STATUS registers.
// Optional feature macro: UART_RX_IRQ_EN adds the irq output and the STATUS.irq_en bit.
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 8,
    parameter int BASE_ADDR    = 1032
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef UART_RX_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] rdata
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0] DATA_ADDR = 32'(BASE_ADDR);
    localparam logic [31:0] STAT_ADDR = 32'(BASE_ADDR + 4);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state, state_next;
    logic             sync1, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_clr, shift_en, stop_ok, stop_bad;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, count;
    logic             empty, full, push, pop, ovr_set;
    logic             ovr, ferr, irq_en;
    logic             rd_data_hit, rd_stat_hit, wr_stat;
    logic [31:0]      status_word;
    logic             unused_wdata;

    assign unused_wdata = ^{wdata[31:4], wdata[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            {sync1, rx_s, rx_prev} <= 3'b111;
        end else begin
            sync1   <= uart_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: if (rx_prev && !rx_s) begin
                state_next = S_START;
                cnt_clr    = 1'b1;
            end
            S_START: if (cnt == HALF_LAST) begin
                cnt_clr    = 1'b1;
                state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (cnt == BIT_LAST) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
                if (bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: if (cnt == BIT_LAST) begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    stop_ok    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    stop_bad   = 1'b1;
                    state_next = S_BREAK;
                end
            end
            S_BREAK: if (rx_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Bits arrive LSB first, so shifting in from the top leaves bit 0 in shreg[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == S_IDLE) bit_idx <= '0;
            else if (shift_en)   bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign rd_data_hit = mem_en && mem_read && (addr == DATA_ADDR);
    assign rd_stat_hit = mem_en && mem_read && (addr == STAT_ADDR);
    assign wr_stat     = mem_en && !mem_read && (addr == STAT_ADDR);

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rd_data_hit && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push    = stop_ok && (!full || pop);
    assign ovr_set = stop_ok && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Setting a flag beats a write-1-to-clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  | (ovr  & ~(wr_stat & wdata[2]));
            ferr <= stop_bad | (ferr & ~(wr_stat & wdata[3]));
        end
    end

`ifdef UART_RX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_stat) irq_en <= wdata[8];
            irq <= irq_en & (!empty | ovr | ferr);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        status_word      = '0;
        status_word[0]   = !empty;
        status_word[1]   = full;
        status_word[2]   = ovr;
        status_word[3]   = ferr;
        status_word[7:4] = 4'(count);
        status_word[8]   = irq_en;
    end

    // rdata idles at zero so it can be OR-combined with the other bus responders.
    always_ff @(posedge clk) begin
        if (rst)              rdata <= '0;
        else if (rd_data_hit) rdata <= empty ? '0 : {24'b0, fifo_mem[rd_ptr[AW-1:0]]};
        else if (rd_stat_hit) rdata <= status_word;
        else                  rdata <= '0;
    end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: directed table, corner-case sequences, randomized traffic vs. a queue model.
module tb_uart_rx_mmio;
    localparam int CPB = 8;
    localparam logic [31:0] DATA_A = 32'd1032;
    localparam logic [31:0] STAT_A = 32'd1036;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
`ifdef UART_RX_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_q[$];
    bit         m_ovr, m_ferr, m_irq_en;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .BASE_ADDR(1032)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .mem_en   (mem_en),
        .mem_read (mem_read),
        .addr     (addr),
        .wdata    (wdata),
`ifdef UART_RX_IRQ_EN
        .irq      (irq),
`endif
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not yet printed");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // All bus/serial tasks start and end on a falling clock edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mem_en = 1'b1; mem_read = 1'b1; addr = a;
        @(negedge clk);
        mem_en = 1'b0; mem_read = 1'b0;
        d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_en = 1'b1; mem_read = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        mem_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_bits(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b);
        uart_rx = 1'b1;
        repeat (CPB + 3) @(negedge clk);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_bits(b);
        uart_rx = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (m_q.size() != 0);
        s[1]   = (m_q.size() == 8);
        s[2]   = m_ovr;
        s[3]   = m_ferr;
        s[7:4] = 4'(m_q.size());
        s[8]   = m_irq_en;
        return s;
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          op;

        tbl[0]  = '{1'b0, STAT_A, 32'h0, 32'h87};
        tbl[1]  = '{1'b1, DATA_A, 32'hFF, 32'h0};
        tbl[2]  = '{1'b0, 32'd1028, 32'h0, 32'h0};
        for (int i = 3; i <= 10; i++) tbl[i] = '{1'b0, DATA_A, 32'h0, 32'(i - 2)};
        tbl[11] = '{1'b0, DATA_A, 32'h0, 32'h0};
        tbl[12] = '{1'b0, STAT_A, 32'h0, 32'h04};
        tbl[13] = '{1'b1, STAT_A, 32'h4, 32'h0};
        tbl[14] = '{1'b0, STAT_A, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 32'd1040, 32'h0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
`ifdef UART_RX_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);
        read_check("rst_status", STAT_A, 32'h0);
        read_check("rst_data", DATA_A, 32'h0);

        // Single byte
        send_frame(8'hA5);
        read_check("a5_status", STAT_A, 32'h11);
        read_check("a5_data", DATA_A, 32'hA5);
        read_check("a5_status_after", STAT_A, 32'h0);

        // Overflow, then the directed register table
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].a, tbl[i].d);
                check($sformatf("tbl[%0d]", i), rdata, tbl[i].exp);
            end else begin
                read_check($sformatf("tbl[%0d]", i), tbl[i].a, tbl[i].exp);
            end
        end

        // Framing error with the line held low through three bit times
        send_bits(8'h3C);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        read_check("ferr_status_low1", STAT_A, 32'h08);
        repeat (CPB) @(negedge clk);
        read_check("ferr_status_low2", STAT_A, 32'h08);
        repeat (CPB - 2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        read_check("ferr_status_high", STAT_A, 32'h08);
        bus_write(STAT_A, 32'h8);
        read_check("ferr_cleared", STAT_A, 32'h0);
        send_frame(8'h55);
        read_check("after_ferr_status", STAT_A, 32'h11);
        read_check("after_ferr_data", DATA_A, 32'h55);

        // Short glitch on an idle line
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        read_check("glitch_status", STAT_A, 32'h0);
        send_frame(8'h5A);
        read_check("glitch_next_data", DATA_A, 32'h5A);

        // Full FIFO: pop lands on the same edge as the stop-bit push
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i));
        read_check("full_status", STAT_A, 32'h83);
        send_bits(8'hEE);
        uart_rx = 1'b1;
        repeat (CPB - 2) @(negedge clk);
        read_check("coincide_pop", DATA_A, 32'h10);
        repeat (CPB) @(negedge clk);
        read_check("coincide_status", STAT_A, 32'h83);
        for (int i = 1; i < 8; i++) read_check("coincide_drain", DATA_A, 32'(8'h10 + i));
        read_check("coincide_last", DATA_A, 32'hEE);
        read_check("coincide_empty", STAT_A, 32'h0);

`ifdef UART_RX_IRQ_EN
        bus_write(STAT_A, 32'h100);
        read_check("irq_en_status", STAT_A, 32'h100);
        send_bits(8'h7E);
        uart_rx = 1'b1;
        repeat (CPB - 1) @(negedge clk);
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'h1);
        read_check("irq_data", DATA_A, 32'h7E);
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_drop", {31'b0, irq}, 32'h0);
`else
        bus_write(STAT_A, 32'h100);
        read_check("irq_en_absent", STAT_A, 32'h0);
`endif

        // Reset in the middle of a frame
        send_frame(8'h33);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        read_check("midrst_status", STAT_A, 32'h0);
        read_check("midrst_data", DATA_A, 32'h0);

        // Randomized traffic against the queue model
        m_q.delete();
        m_ovr = 0; m_ferr = 0; m_irq_en = 0;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                b = 8'($urandom);
                if (op == 0 && $urandom_range(0, 3) == 0) begin
                    send_bad(b);
                    m_ferr = 1;
                end else begin
                    send_frame(b);
                    if (m_q.size() < 8) m_q.push_back(b);
                    else                m_ovr = 1;
                end
            end else if (op <= 6) begin
                bus_read(DATA_A, d);
                check("rnd_data", d, (m_q.size() != 0) ? {24'b0, m_q.pop_front()} : 32'h0);
            end else if (op <= 8) begin
                read_check("rnd_status", STAT_A, model_status());
            end else begin
                d = $urandom & 32'h10C;
                bus_write(STAT_A, d);
                if (d[2]) m_ovr = 0;
                if (d[3]) m_ferr = 0;
`ifdef UART_RX_IRQ_EN
                m_irq_en = d[8];
`endif
            end
`ifdef UART_RX_IRQ_EN
            @(negedge clk);
            check("rnd_irq", {31'b0, irq},
                  {31'b0, m_irq_en & ((m_q.size() != 0) | m_ovr | m_ferr)});
`endif
        end
        read_check("rnd_final_status", STAT_A, model_status());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver that answers the CPU's data bus (`mem_en`/`mem_read`/`addr`) as a bus responder. It deserialises 8N1 frames from `uart_rx` into an 8-entry FIFO and exposes a DATA register (read-to-pop) and a STATUS register. It sits beside the RAM and the LED register in the top-level address map, clocked by the CPU clock.

## Interface
- `CLKS_PER_BIT`, 234, clock cycles per bit (27 MHz / 115200); must be ≥ 4
- `FIFO_DEPTH`, 8, receive FIFO entries; power of two
- `BASE_ADDR`, 1032, byte address of DATA; STATUS is at `BASE_ADDR+4`

Ports:
- `clk`  in  1  CPU clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `uart_rx`  in  1  serial input, idle high, asynchronous to `clk`
- `mem_en`  in  1  bus access strobe, one cycle per access
- `mem_read`  in  1  1 = read, 0 = write (qualified by `mem_en`)
- `addr`  in  32  byte address; full 32-bit compare
- `wdata`  in  32  write data from the CPU
- `rdata`  out  32  registered read data
- `irq`  out  1  present only with `UART_RX_IRQ_EN`

## Operation
- Input path: 2-flop synchroniser on `uart_rx`, reset to 1; the receiver sees only the synchronised value.
- Receiver FSM:
  - IDLE: a 1→0 transition moves to START and the bit counter is cleared.
  - START: at `CLKS_PER_BIT/2` the line is sampled. Low → DATA. High → IDLE (glitch; nothing recorded).
  - DATA: 8 samples, each `CLKS_PER_BIT` apart, shifted in LSB first, then → STOP.
  - STOP: one sample after `CLKS_PER_BIT`.
    - High, FIFO not full → push the byte, then IDLE.
    - High, FIFO full → drop the byte, set `ovr`, then IDLE.
    - Low → drop the byte, set `ferr`, go to BREAK_WAIT.
  - BREAK_WAIT: stays until the line is sampled high, then → IDLE.
- Register map:
  - DATA read: returns `{24'b0, head byte}` and pops. With the FIFO empty it returns 0 and the pointers are unchanged.
  - DATA write: ignored.
  - STATUS read bits: [0] `valid` (FIFO not empty), [1] `full`, [2] `ovr`, [3] `ferr`, [7:4] occupancy count, [8] `irq_en`. All other bits 0.
  - STATUS write: a 1 in bit 2 or bit 3 clears that flag (write-1-to-clear). Bit 8 is written directly as `irq_en`.
- `rdata` is 0 in any cycle that does not follow a read to DATA or STATUS, so it can be OR-combined with other responders.
- FIFO: separate read and write pointers one bit wider than `log2(FIFO_DEPTH)`, so full and empty are distinct. Pointers wrap modulo 2·DEPTH.

## Timing
- Reset: `rdata`=0, `irq`=0, FIFO empty, `ovr`=`ferr`=`irq_en`=0, FSM=IDLE, synchroniser=1. A frame in progress when `rst` is asserted is discarded.
- Read latency is 1 cycle. `rdata` is valid in the cycle after `mem_en && mem_read && addr` hits a register. A DATA pop takes effect at the same edge.
- Writes take effect at the edge where `mem_en && !mem_read` is sampled.
- A byte is pushed at the edge of its stop-bit sample, about 2 + 9.5·`CLKS_PER_BIT` cycles after the start edge reaches the pin. STATUS.valid reads 1 for any read issued on the following cycle.
- Simultaneous push and pop:
  - FIFO full: both succeed, occupancy stays the same, `ovr` is not set.
  - FIFO empty: the pop reads 0, the push lands, and the next DATA read returns the byte.
- Simultaneous event and W1C on the same edge: setting a flag wins over clearing it.
- Reading STATUS has no side effects.

## Configuration
- `UART_RX_IRQ_EN` defined: the `irq` port exists and is registered as `irq_en & (valid | ovr | ferr)`, updating one cycle after the source changes.
- Not defined: no `irq` port, STATUS bit 8 reads 0, and writes to bit 8 are ignored.

## Test plan
- Reset, then send 0xA5 at `CLKS_PER_BIT`=8 → STATUS reads 0x11. DATA read returns 0x000000A5. STATUS then reads 0x00.
- Send 9 bytes 0x01..0x09 with no reads → 9th byte dropped, STATUS = 0x87. DATA reads return 0x01..0x08 in order, then 0. Writing 0x4 to STATUS clears `ovr`.
- Frame 0x3C with the stop bit held low for 3 bit times → `ferr`=1, FIFO stays empty, no byte is received until the line returns high. The next frame 0x55 is received correctly.
- 2-cycle low glitch on an idle line → FSM returns to IDLE and STATUS stays 0.
- FIFO full while a DATA read coincides with a push edge → occupancy remains 8 and `ovr` stays 0. Also assert `rst` mid-frame → FIFO empty and the partial frame is discarded.
- `UART_RX_IRQ_EN`: write 0x100 to STATUS, send 0x7E → `irq` rises 1 cycle after the push. A DATA read returns 0x7E and `irq` drops the cycle after the pop.
